bsg_link_oddr_tx_sched: RTL and testbench

- Transmit-side scheduler in front of the bsg_link DDR output PHY.
- Shares one PHY between num_chan_p requester channels using credit-gated round-robin arbitration.
- Packs each grant into one 2*width_p PHY word as {valid, chan_id, payload}.
- After reset, runs a training sequence before opening the link to traffic.

---
 rtl/bsg_link_oddr_pkg.sv | 29 ++
 rtl/bsg_link_credit_counter.sv | 37 +++
 rtl/bsg_link_oddr_tx_sched.sv | 158 +++++++++++++++
 tb/tb_bsg_link_oddr_tx_sched.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/bsg_link_oddr_pkg.sv
// rtl/bsg_link_oddr_pkg.sv - shared constants, state enum and frame layout helpers for the oddr tx scheduler
// Contents:
//   train_*_nibble_c : nibble repeated across the PHY word during link training
//   link_state_e     : scheduler FSM states
//   frame_*          : bit positions of the {valid, id, payload, pad} PHY frame
package bsg_link_oddr_pkg;

   localparam logic [3:0] train_even_nibble_c = 4'hA;
   localparam logic [3:0] train_odd_nibble_c  = 4'h5;

   typedef enum logic {
      TRAIN  = 1'b0,
      ACTIVE = 1'b1
   } link_state_e;

   // The frame is MSB-aligned in the 2*width PHY word; unused LSBs are zero pad.
   function automatic int frame_valid_pos(input int width);
      return 2*width - 1;
   endfunction

   function automatic int frame_id_lsb(input int width, input int id_width);
      return 2*width - 1 - id_width;
   endfunction

   function automatic int frame_payload_lsb(input int width, input int id_width, input int payload_width);
      return 2*width - 1 - id_width - payload_width;
   endfunction

endpackage

// File: rtl/bsg_link_credit_counter.sv
// rtl/bsg_link_credit_counter.sv - saturating up/down credit counter for one link channel
// Ports:
//   clk_i, reset_i : clock, synchronous active-low reset (loads credits_p)
//   up_i           : one credit returned this cycle
//   down_i         : one credit consumed this cycle
//   count_o        : current credit count
//   zero_o, sat_o  : count is 0 / count is credits_p
module bsg_link_credit_counter #(
   parameter int credits_p  = 8,
   parameter int cred_width = $clog2(credits_p+1)
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  up_i,
   input  logic                  down_i,
   output logic [cred_width-1:0] count_o,
   output logic                  zero_o,
   output logic                  sat_o
);

   localparam logic [cred_width-1:0] max_count = cred_width'(credits_p);

   assign zero_o = (count_o == '0);
   assign sat_o  = (count_o == max_count);

   // Simultaneous up and down cancel; both ends hold rather than wrap.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         count_o <= max_count;
      end else if (up_i && !down_i && !sat_o) begin
         count_o <= count_o + 1'b1;
      end else if (down_i && !up_i && !zero_o) begin
         count_o <= count_o - 1'b1;
      end
   end

endmodule

// File: rtl/bsg_link_oddr_tx_sched.sv
// rtl/bsg_link_oddr_tx_sched.sv - credit-gated round-robin scheduler feeding the bsg_link DDR output PHY
// Ports:
//   clk_i, reset_i  : clock, synchronous active-low link reset
//   v_i, data_i     : per-channel request valid and payload (channel c at c*payload_width_p)
//   yumi_o          : one-hot consume strobe, same cycle as the grant
//   credit_return_i : one pulse per credit returned by the receiver
//   phy_ready_i     : PHY captures phy_data_o in cycles where this is high
//   phy_data_o      : combinational PHY word, idle (zero) when nothing is sent
//   link_up_o       : training finished, traffic enabled
//   credit_o        : packed per-channel credit counts
module bsg_link_oddr_tx_sched
   import bsg_link_oddr_pkg::*;
#(
   parameter  int width_p         = 64,
   parameter  int num_chan_p      = 4,
   parameter  int payload_width_p = 120,
   parameter  int credits_p       = 8,
   parameter  int train_words_p   = 16,
   localparam int id_width        = ($clog2(num_chan_p) < 1) ? 1 : $clog2(num_chan_p),
   localparam int cred_width      = $clog2(credits_p+1)
) (
   input  logic                                  clk_i,
   input  logic                                  reset_i,
   input  logic [num_chan_p-1:0]                 v_i,
   input  logic [num_chan_p*payload_width_p-1:0] data_i,
   output logic [num_chan_p-1:0]                 yumi_o,
   input  logic [num_chan_p-1:0]                 credit_return_i,
   input  logic                                  phy_ready_i,
   output logic [2*width_p-1:0]                  phy_data_o,
   output logic                                  link_up_o,
   output logic [num_chan_p*cred_width-1:0]      credit_o
);

   localparam int frame_w    = 2*width_p;
   localparam int valid_pos  = frame_valid_pos(width_p);
   localparam int id_lsb     = frame_id_lsb(width_p, id_width);
   localparam int pl_lsb     = frame_payload_lsb(width_p, id_width, payload_width_p);
   localparam int tcnt_width = (train_words_p > 1) ? $clog2(train_words_p) : 1;

   typedef logic [id_width-1:0]   id_t;
   typedef logic [tcnt_width-1:0] tcnt_t;

   if (payload_width_p + id_width + 1 > 2*width_p) begin : g_bad_frame
      $error("bsg_link_oddr_tx_sched: payload, id and valid do not fit in the PHY word");
   end
   if (num_chan_p < 2) begin : g_bad_chan
      $error("bsg_link_oddr_tx_sched: num_chan_p must be at least 2");
   end
   if (train_words_p < 1) begin : g_bad_train
      $error("bsg_link_oddr_tx_sched: train_words_p must be at least 1");
   end

   link_state_e state_r, state_n;
   tcnt_t       tcnt_r, tcnt_n;
   id_t         rr_r, rr_n;

   logic [payload_width_p-1:0] data_arr [num_chan_p];
   logic [num_chan_p-1:0]      cred_up, cred_zero, cred_sat, eligible;
   logic [frame_w-1:0]         train_even_word, train_odd_word;
   logic                       grant_v;
   id_t                        grant_id;
   id_t                        scan_id;

   for (genvar b = 0; b < frame_w; b++) begin : g_train_word
      assign train_even_word[b] = train_even_nibble_c[b % 4];
      assign train_odd_word[b]  = train_odd_nibble_c[b % 4];
   end

   for (genvar c = 0; c < num_chan_p; c++) begin : g_chan
      assign data_arr[c] = data_i[c*payload_width_p +: payload_width_p];
      // Returns arriving before link-up belong to the previous session and are dropped.
      assign cred_up[c]  = credit_return_i[c] & (state_r == ACTIVE);

      bsg_link_credit_counter #(
         .credits_p (credits_p),
         .cred_width(cred_width)
      ) u_credit (
         .clk_i  (clk_i),
         .reset_i(reset_i),
         .up_i   (cred_up[c]),
         .down_i (yumi_o[c]),
         .count_o(credit_o[c*cred_width +: cred_width]),
         .zero_o (cred_zero[c]),
         .sat_o  (cred_sat[c])
      );
   end

   assign eligible  = v_i & ~cred_zero;
   assign link_up_o = (state_r == ACTIVE);

   always_comb begin
      state_n    = state_r;
      tcnt_n     = tcnt_r;
      rr_n       = rr_r;
      yumi_o     = '0;
      phy_data_o = '0;
      grant_v    = 1'b0;
      grant_id   = '0;
      scan_id    = '0;

      // Rotating priority scan: first eligible channel at or after rr_r.
      for (int i = 0; i < num_chan_p; i++) begin
         scan_id = id_t'((int'(rr_r) + i) % num_chan_p);
         if (!grant_v && eligible[scan_id]) begin
            grant_v  = 1'b1;
            grant_id = scan_id;
         end
      end

      // Nothing leaves the block while reset is held, regardless of registered state.
      if (reset_i && phy_ready_i) begin
         case (state_r)
            TRAIN: begin
               phy_data_o = tcnt_r[0] ? train_odd_word : train_even_word;
               if (tcnt_r == tcnt_t'(train_words_p-1)) begin
                  state_n = ACTIVE;
               end else begin
                  tcnt_n = tcnt_r + 1'b1;
               end
            end
            ACTIVE: begin
               if (grant_v) begin
                  yumi_o[grant_id]                         = 1'b1;
                  phy_data_o[valid_pos]                    = 1'b1;
                  phy_data_o[id_lsb +: id_width]           = grant_id;
                  phy_data_o[pl_lsb +: payload_width_p]    = data_arr[grant_id];
                  rr_n = (grant_id == id_t'(num_chan_p-1)) ? '0 : grant_id + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         state_r <= TRAIN;
         tcnt_r  <= '0;
         rr_r    <= '0;
      end else begin
         state_r <= state_n;
         tcnt_r  <= tcnt_n;
         rr_r    <= rr_n;
      end
   end

   // A return with the counter already full means the receiver handed back
   // a credit it never held; the counter clamps but this is a protocol bug.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int c = 0; c < num_chan_p; c++) begin
            assert (!(cred_up[c] && !yumi_o[c] && cred_sat[c]));
         end
      end
   end

endmodule

// File: tb/tb_bsg_link_oddr_tx_sched.sv
// tb/tb_bsg_link_oddr_tx_sched.sv - directed self-checking bench for bsg_link_oddr_tx_sched
module tb_bsg_link_oddr_tx_sched;

   localparam int W  = 64;
   localparam int N  = 4;
   localparam int P  = 120;
   localparam int CW = 4;

   localparam logic [127:0] train_a = {32{4'hA}};
   localparam logic [127:0] train_5 = {32{4'h5}};

   logic             clk = 1'b0;
   logic             reset_i;
   logic [N-1:0]     v_i;
   logic [N*P-1:0]   data_i;
   logic [N-1:0]     yumi_o;
   logic [N-1:0]     ret;
   logic             phy_ready_i;
   logic [2*W-1:0]   phy_data_o;
   logic             link_up_o;
   logic [N*CW-1:0]  credit_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bsg_link_oddr_tx_sched #(
      .width_p        (W),
      .num_chan_p     (N),
      .payload_width_p(P),
      .credits_p      (8),
      .train_words_p  (16)
   ) dut (
      .clk_i          (clk),
      .reset_i        (reset_i),
      .v_i            (v_i),
      .data_i         (data_i),
      .yumi_o         (yumi_o),
      .credit_return_i(ret),
      .phy_ready_i    (phy_ready_i),
      .phy_data_o     (phy_data_o),
      .link_up_o      (link_up_o),
      .credit_o       (credit_o)
   );

   function automatic logic [P-1:0] pay(input int c);
      logic [7:0] b;
      b = 8'(8'h11 * (c + 1));
      return {15{b}};
   endfunction

   function automatic logic [127:0] frame(input int c);
      logic [1:0] id;
      id = 2'(c);
      return {1'b1, id, pay(c), 5'b0};
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the edge; outputs are sampled 1 unit later.
   task automatic tick(input logic rst, input logic rdy, input logic [N-1:0] v, input logic [N-1:0] r);
      @(posedge clk);
      #1;
      reset_i     = rst;
      phy_ready_i = rdy;
      v_i         = v;
      ret         = r;
      #1;
   endtask

   task automatic out(input string tag, input logic [N-1:0] y, input logic [127:0] d);
      chk({tag, ".yumi"}, 128'(yumi_o), 128'(y));
      chk({tag, ".data"}, phy_data_o, d);
   endtask

   // 16 training words on alternate cycles, with all channels requesting and a
   // stray credit return that must be ignored.
   task automatic train();
      for (int k = 0; k < 31; k++) begin
         tick(1'b1, (k % 2 == 0), 4'hF, (k == 1) ? 4'hF : 4'h0);
         out($sformatf("train%0d", k), 4'h0,
             (k % 2 == 1) ? 128'h0 : (((k / 2) % 2 == 0) ? train_a : train_5));
         chk($sformatf("train%0d.link_up", k), 128'(link_up_o), 128'h0);
         if (k == 0) chk("train_start.credit", 128'(credit_o), 128'({4{4'd8}}));
      end
      tick(1'b1, 1'b0, 4'hF, 4'h0);
      chk("link_up", 128'(link_up_o), 128'h1);
      out("link_up_idle", 4'h0, 128'h0);
      chk("link_up.credit", 128'(credit_o), 128'({4{4'd8}}));
   endtask

   initial begin
      reset_i     = 1'b0;
      phy_ready_i = 1'b0;
      v_i         = '0;
      ret         = '0;
      data_i      = {pay(3), pay(2), pay(1), pay(0)};

      tick(1'b0, 1'b0, 4'h0, 4'h0);
      tick(1'b0, 1'b0, 4'h0, 4'h0);
      tick(1'b0, 1'b1, 4'hF, 4'h0);
      out("reset", 4'h0, 128'h0);
      chk("reset.link_up", 128'(link_up_o), 128'h0);
      chk("reset.credit", 128'(credit_o), 128'({4{4'd8}}));

      train();

      // Round robin with every channel eligible: 0,1,2,3,0,1,2,3,0
      for (int j = 0; j < 18; j++) begin
         tick(1'b1, (j % 2 == 0), 4'hF, 4'h0);
         if (j % 2 == 0) out($sformatf("rr%0d", j / 2), 4'(1 << ((j / 2) % 4)), frame((j / 2) % 4));
         else            out($sformatf("rr_gap%0d", j), 4'h0, 128'h0);
      end

      // PHY not ready: nothing moves, then arbitration resumes at channel 1
      for (int i = 0; i < 5; i++) begin
         tick(1'b1, 1'b0, 4'hF, 4'h0);
         out($sformatf("notready%0d", i), 4'h0, 128'h0);
         chk($sformatf("notready%0d.credit", i), 128'(credit_o), 128'({4'd6, 4'd6, 4'd6, 4'd5}));
      end
      tick(1'b1, 1'b1, 4'hF, 4'h0);
      out("resume", 4'b0010, frame(1));
      tick(1'b1, 1'b0, 4'hF, 4'h0);
      chk("resume.credit", 128'(credit_o), 128'({4'd6, 4'd6, 4'd5, 4'd5}));

      // Reset mid-traffic: outputs idle during reset, then training restarts
      tick(1'b0, 1'b1, 4'hF, 4'h0);
      out("rst_mid", 4'h0, 128'h0);
      train();

      tick(1'b1, 1'b1, 4'hF, 4'h0);
      out("rr_after_reset", 4'b0001, frame(0));

      // Credit exhaustion on channel 2
      for (int i = 0; i < 20; i++) begin
         tick(1'b1, (i % 2 == 0), 4'b0100, 4'h0);
         if (i % 2 == 0 && i < 16) out($sformatf("exh%0d", i), 4'b0100, frame(2));
         else                      out($sformatf("exh_idle%0d", i), 4'h0, 128'h0);
      end
      chk("exhausted.credit", 128'(credit_o), 128'({4'd8, 4'd0, 4'd8, 4'd7}));
      tick(1'b1, 1'b0, 4'b0100, 4'b0100);
      out("ret_pulse", 4'h0, 128'h0);
      tick(1'b1, 1'b1, 4'b0100, 4'h0);
      out("after_ret", 4'b0100, frame(2));
      chk("after_ret.credit", 128'(credit_o), 128'({4'd8, 4'd1, 4'd8, 4'd7}));
      tick(1'b1, 1'b0, 4'b0100, 4'h0);
      tick(1'b1, 1'b1, 4'b0100, 4'h0);
      out("reexhausted", 4'h0, 128'h0);

      // Channel 1 down to 3 credits, then grant with a simultaneous return
      for (int i = 0; i < 10; i++) begin
         tick(1'b1, (i % 2 == 0), 4'b0010, 4'h0);
         if (i % 2 == 0) out($sformatf("ch1_%0d", i), 4'b0010, frame(1));
         else            out($sformatf("ch1_idle%0d", i), 4'h0, 128'h0);
      end
      tick(1'b1, 1'b1, 4'b0010, 4'b0010);
      out("grant_and_ret", 4'b0010, frame(1));
      chk("grant_and_ret.credit_before", 128'(credit_o[7:4]), 128'd3);
      tick(1'b1, 1'b0, 4'b0010, 4'h0);
      chk("grant_and_ret.credit_after", 128'(credit_o), 128'({4'd8, 4'd0, 4'd3, 4'd7}));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
